// File: rtl/updown_ctrl_pkg.sv
// Shared op-codes, FSM state encoding and direction constants for the
// up/down counter sequencer.
package updown_ctrl_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD     = 2'b00;
  localparam logic [OP_W-1:0] OP_UP       = 2'b01;
  localparam logic [OP_W-1:0] OP_DOWN     = 2'b10;
  localparam logic [OP_W-1:0] OP_PINGPONG = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/updown_counter_core.sv
// Counter datapath register: parallel load (priority) or one modulo step
// per enabled edge. Flags describe the current value and the pending step.
module updown_counter_core
  import updown_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap_next
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (ld) begin
      count_d = ld_val;
    end else if (en) begin
      count_d = (dir == DIR_DOWN) ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count     = count_q;
  assign at_max    = (count_q == {WIDTH{1'b1}});
  assign at_zero   = (count_q == '0);
  // A step crosses the modulo boundary when it leaves max upward or zero downward.
  assign wrap_next = en && !ld && ((dir == DIR_UP) ? at_max : at_zero);

endmodule

// File: rtl/updown_count_ctrl.sv
// Command sequencer for the up/down counter: accepts LOAD/UP/DOWN/PINGPONG
// over valid/ready, steps once per clock and reports done/wrap/aborted.
module updown_count_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic              mode,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic              aborted
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              mode_q, mode_d;
  logic              pp_q, pp_d;
  logic              done_q, done_d;
  logic              wrap_q;
  logic              aborted_q, aborted_d;

  logic              core_en, core_dir, core_ld;
  logic              at_max, at_zero, wrap_next;
  logic              accept, n_zero;

  assign accept = cmd_valid && (state_q == IDLE);
  assign n_zero = (cmd_arg == '0);

  updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .en        (core_en),
    .dir       (core_dir),
    .ld        (core_ld),
    .ld_val    (cmd_arg[WIDTH-1:0]),
    .count     (count),
    .at_max    (at_max),
    .at_zero   (at_zero),
    .wrap_next (wrap_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && cmd_op != OP_LOAD && !n_zero) state_d = RUN;
      RUN:  if (abort || rem_q == STEP_W'(1))           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_en   = 1'b0;
    core_dir  = mode_q;
    core_ld   = 1'b0;
    mode_d    = mode_q;
    rem_d     = rem_q;
    pp_d      = pp_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD: begin
              core_ld = 1'b1;
              done_d  = 1'b1;
            end
            OP_UP, OP_DOWN: begin
              mode_d = (cmd_op == OP_DOWN) ? DIR_DOWN : DIR_UP;
              done_d = n_zero;
              rem_d  = cmd_arg;
              pp_d   = 1'b0;
            end
            default: begin
              done_d = n_zero;
              rem_d  = cmd_arg;
              pp_d   = 1'b1;
            end
          endcase
        end
      end
      RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          rem_d     = '0;
        end else begin
          core_en = 1'b1;
          // Ping-pong reverses at the end stops instead of wrapping.
          if (pp_q && mode_q == DIR_UP && at_max) begin
            core_dir = DIR_DOWN;
            mode_d   = DIR_DOWN;
          end else if (pp_q && mode_q == DIR_DOWN && at_zero) begin
            core_dir = DIR_UP;
            mode_d   = DIR_UP;
          end
          rem_d  = rem_q - STEP_W'(1);
          done_d = (rem_q == STEP_W'(1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q     <= '0;
      mode_q    <= DIR_UP;
      pp_q      <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      mode_q    <= mode_d;
      pp_q      <= pp_d;
      done_q    <= done_d;
      wrap_q    <= wrap_next;
      aborted_q <= aborted_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign mode      = mode_q;
  assign done      = done_q;
  assign wrap      = wrap_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Directed bench for updown_count_ctrl with hand-computed expectations
// (WIDTH=3, STEP_W=8).
module tb_updown_count_ctrl;

  localparam int unsigned WIDTH  = 3;
  localparam int unsigned STEP_W = 8;

  localparam logic [1:0] OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_PP = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;
  logic              abort;
  logic [WIDTH-1:0]  count;
  logic              mode, busy, done, wrap, aborted;

  int n_tests = 0;
  int n_fail  = 0;

  updown_count_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .abort     (abort),
    .count     (count),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [STEP_W-1:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Checks count, mode, busy, done, wrap, aborted in one call.
  task automatic chk_all(input string tag, input int c, input int m, input int b,
                         input int d, input int w, input int a);
    chk({tag, ".count"},   int'(count),   c);
    chk({tag, ".mode"},    int'(mode),    m);
    chk({tag, ".busy"},    int'(busy),    b);
    chk({tag, ".done"},    int'(done),    d);
    chk({tag, ".wrap"},    int'(wrap),    w);
    chk({tag, ".aborted"}, int'(aborted), a);
  endtask

  int exp_pp [6] = '{6, 7, 6, 5, 4, 3};
  int exp_pm [6] = '{0, 0, 1, 1, 1, 1};

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; abort = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_all("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.ready", int'(cmd_ready), 1);

    // LOAD with junk in the upper bits: only the low 3 bits matter
    issue(OP_LOAD, 8'hFD);
    chk_all("load5", 5, 0, 0, 1, 0, 0);
    chk("load5.ready", int'(cmd_ready), 1);
    tick();
    chk("load5.done_pulse", int'(done), 0);

    // UP 3 from 6: 7, 0 (wrap), 1 (done)
    issue(OP_LOAD, 8'd6);
    issue(OP_UP, 8'd3);
    chk_all("up.acc", 6, 0, 1, 0, 0, 0);
    chk("up.ready", int'(cmd_ready), 0);
    tick(); chk_all("up.s1", 7, 0, 1, 0, 0, 0);
    tick(); chk_all("up.s2", 0, 0, 1, 0, 1, 0);
    tick(); chk_all("up.s3", 1, 0, 0, 1, 0, 0);
    chk("up.ready_done", int'(cmd_ready), 1);

    // DOWN 2 from 1: 0, 7 (wrap + done)
    issue(OP_DOWN, 8'd2);
    chk_all("dn.acc", 1, 1, 1, 0, 0, 0);
    tick(); chk_all("dn.s1", 0, 1, 1, 0, 0, 0);
    tick(); chk_all("dn.s2", 7, 1, 0, 1, 1, 0);

    // Force mode=0 with UP 0, then PINGPONG 6 from 5
    issue(OP_UP, 8'd0);
    chk_all("up0", 7, 0, 0, 1, 0, 0);
    issue(OP_LOAD, 8'd5);
    issue(OP_PP, 8'd6);
    chk_all("pp.acc", 5, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all($sformatf("pp.s%0d", i + 1), exp_pp[i], exp_pm[i],
              (i < 5) ? 1 : 0, (i == 5) ? 1 : 0, 0, 0);
    end

    // UP 200 from 3, abort in the 4th RUN cycle: 3 steps taken
    issue(OP_LOAD, 8'd3);
    issue(OP_UP, 8'd200);
    tick(); tick(); tick();
    chk_all("ab.s3", 6, 0, 1, 0, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_all("ab.hit", 6, 0, 0, 0, 0, 1);
    chk("ab.ready", int'(cmd_ready), 1);
    tick();
    chk_all("ab.after", 6, 0, 0, 0, 0, 0);

    // Reset mid-run of DOWN 10
    issue(OP_DOWN, 8'd10);
    tick(); tick();
    chk_all("rr.run", 4, 1, 1, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all("rr.rst", 0, 0, 0, 0, 0, 0);
    chk("rr.ready", int'(cmd_ready), 1);

    // Waiting cmd_valid with ready low is not sampled
    issue(OP_UP, 8'd2);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_arg = 8'd7;
    tick();
    chk_all("nv.s1", 1, 0, 1, 0, 0, 0);
    cmd_valid = 1'b0;
    tick();
    chk_all("nv.s2", 2, 0, 0, 1, 0, 0);

    // UP 0 with mode=1, then LOAD back-to-back with abort alongside
    issue(OP_LOAD, 8'd3);
    issue(OP_DOWN, 8'd0);
    chk_all("b2b.dn0", 3, 1, 0, 1, 0, 0);
    issue(OP_UP, 8'd0);
    chk_all("b2b.up0", 3, 0, 0, 1, 0, 0);
    chk("b2b.ready", int'(cmd_ready), 1);
    abort = 1'b1;
    issue(OP_LOAD, 8'd4);
    abort = 1'b0;
    chk_all("b2b.load", 4, 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_count_ctrl.md
Name: updown_count_ctrl

Overview:
Command-driven sequencer for a synchronous WIDTH-bit up/down counter. It accepts LOAD / UP / DOWN / PINGPONG commands over a valid/ready handshake and steps the counter once per clock for a programmed number of steps. It reports completion, wrap and abort events. It sits between a host/test controller and the counter datapath, replacing ripple-clocked up/down counting with a single-clock, schedulable counter.

Parameters:
WIDTH, 3, counter width; max count = 2^WIDTH-1
STEP_W, 8, width of step-count argument (WIDTH <= STEP_W)

Ports:
clk  in  1  single system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE; command accepted on edge where valid&&ready
cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 PINGPONG
cmd_arg  in  STEP_W  LOAD: value in low WIDTH bits (upper ignored); others: step count N
abort  in  1  terminate running command
count  out  WIDTH  current counter value (registered)
mode  out  1  current direction, 0=up, 1=down (registered)
busy  out  1  high in RUN
done  out  1  one-cycle pulse: command completed
wrap  out  1  one-cycle pulse: counter wrapped on this step
aborted  out  1  one-cycle pulse: command terminated by abort

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; no other clock or async path.
- Reset (sampled high at an edge, any state): state=IDLE, count=0, mode=0, busy=0, done=0, wrap=0, aborted=0, remaining=0. Reset overrides command acceptance and abort.
- States: IDLE, RUN. cmd_ready = (state==IDLE).
- Pulses done/wrap/aborted are registered and default to 0 each cycle.
- IDLE, accept at edge k:
  - LOAD: count <= cmd_arg[WIDTH-1:0] at edge k; done=1 after edge k; mode unchanged; stay IDLE.
  - UP/DOWN/PINGPONG with N=0: no step; done=1 after edge k; stay IDLE. UP sets mode=0 and DOWN sets mode=1 even for N=0. PINGPONG leaves mode unchanged.
  - UP/DOWN with N>0: mode <= 0/1; remaining <= N; state <= RUN.
  - PINGPONG with N>0: mode unchanged (start direction = current mode); remaining <= N; RUN.
- RUN, per edge, if abort=1: state <= IDLE; no step this edge; aborted=1; done=0; count and mode hold.
- RUN, per edge, otherwise: one step; remaining <= remaining-1. When remaining==1: state <= IDLE and done=1, so the last step and done are visible together after edge k+N. Steps occur on edges k+1..k+N; busy is high for exactly N cycles.
- UP/DOWN step: count ±1 modulo 2^WIDTH. Up from max gives 0 with wrap=1; down from 0 gives max with wrap=1.
- PINGPONG step:
  - If mode=0 and count==max, mode <= 1 and count <= max-1.
  - If mode=1 and count==0, mode <= 0 and count <= 1.
  - Otherwise step in the current direction.
  - wrap is never asserted.
- Back-to-back: cmd_ready is high in the cycle done is high, so a new command can be accepted on the next edge with zero bubble.
- abort while in IDLE is ignored, including in the same cycle as cmd_valid; the command is still accepted.
- cmd_valid without ready: the command is held by the requester; the block does not sample it.

Decomposition:
- Package updown_ctrl_pkg holds:
  - op-code constants OP_LOAD, OP_UP, OP_DOWN, OP_PINGPONG
  - state enum (IDLE, RUN)
  - direction constants DIR_UP=0, DIR_DOWN=1
- Sub-module updown_counter_core (WIDTH) is the datapath register only.
  - Inputs: clk, reset, en, dir, ld, ld_val.
  - Outputs: count, at_max, at_zero, wrap_next.
  - ld takes priority over en.
- The controller holds the FSM, the remaining counter, mode and pingpong turn-around logic, driving dir/en/ld.

Test Plan:
- Reset then LOAD arg=5 -> after accept edge count=5, done=1 for one cycle, mode=0, cmd_ready=1.
- From count=6, UP N=3 -> count 7,0,1 on successive edges; wrap=1 only on the 7->0 step; busy 3 cycles; done with count=1.
- From count=1, DOWN N=2 -> count 0,7; mode=1; wrap on 0->7; done after second step.
- From count=5, mode=0, PINGPONG N=6 -> count 6,7,6,5,4,3; mode switches to 1 at the turn-around; wrap never asserted; done with count=3.
- UP N=200, abort asserted on 4th RUN cycle -> exactly 3 steps taken; aborted=1; done=0; back to IDLE. Then reset high for one edge mid-run of a new command -> count=0, mode=0, busy=0, all pulses 0.
- UP N=0 with mode=1, then LOAD issued back-to-back -> first done with no count change and mode=0; LOAD accepted on the very next edge; abort asserted alongside the LOAD is ignored.
